qsys_sysid_ext: RTL and testbench



---
 rtl/qsys_sysid_ext.sv | 88 ++++++++
 tb/tb_qsys_sysid_ext.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/qsys_sysid_ext.sv
// System-identification slave: ID, build timestamp, capabilities, 64-bit uptime with
// coherent two-word readout, and byte-writable scratch registers on a latency-1 Avalon-MM port.
module qsys_sysid_ext #(
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1496327636,
  parameter int unsigned NUM_SCRATCH = 2,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [ADDR_W-1:0] AddrId    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrTs    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrCaps  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrCtrl  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrUpLo  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AddrUpHi  = ADDR_W'(5);
  localparam logic [31:0]       CapsValue = {16'h0002, 8'd0, 4'd0, 4'(NUM_SCRATCH)};

  logic [63:0] uptime_q, uptime_d;
  logic [31:0] shadow_hi_q;
  logic        uptime_en_q;
  logic [31:0] scratch_q [8];
  logic [31:0] rdata_mux;
  logic [2:0]  scratch_idx;
  logic        scratch_hit;
  logic        ctrl_wr;
  logic        uptime_clr;

  always_comb begin
    scratch_idx = address[2:0];
    scratch_hit = (address[ADDR_W-1:3] == (ADDR_W-3)'(1)) && (32'(scratch_idx) < NUM_SCRATCH);
    ctrl_wr     = write && (address == AddrCtrl);
    uptime_clr  = ctrl_wr && writedata[1];

    // Clear wins over increment.
    if (uptime_clr) begin
      uptime_d = '0;
    end else if (uptime_en_q) begin
      uptime_d = uptime_q + 64'd1;
    end else begin
      uptime_d = uptime_q;
    end

    rdata_mux = '0;
    case (address)
      AddrId:   rdata_mux = ID_VALUE;
      AddrTs:   rdata_mux = TIMESTAMP;
      AddrCaps: rdata_mux = CapsValue;
      AddrCtrl: rdata_mux = {31'd0, uptime_en_q};
      AddrUpLo: rdata_mux = uptime_q[31:0];
      AddrUpHi: rdata_mux = shadow_hi_q;
      default:  if (scratch_hit) rdata_mux = scratch_q[scratch_idx];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      uptime_q      <= '0;
      shadow_hi_q   <= '0;
      uptime_en_q   <= 1'b1;
      for (int i = 0; i < 8; i++) scratch_q[i] <= '0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rdata_mux;
      // Latch the high word alongside the low word so a later HI read is coherent.
      if (read && (address == AddrUpLo)) shadow_hi_q <= uptime_q[63:32];
      uptime_q <= uptime_d;
      if (ctrl_wr) uptime_en_q <= writedata[0];
      if (write && scratch_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch_q[scratch_idx][8*b +: 8] <= writedata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_qsys_sysid_ext.sv
// Directed self-checking bench for qsys_sysid_ext with hand-computed expected values.
module tb_qsys_sysid_ext;

  logic        clock;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  qsys_sysid_ext dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks enter and leave at a falling edge.
  task automatic do_read(input logic [3:0] a, input string tag, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    read = 1'b0;
    check({tag, "_valid"}, {63'd0, readdatavalid}, 64'd1);
    d = readdata;
  endtask

  task automatic rd_chk(input logic [3:0] a, input string tag, input logic [31:0] exp);
    logic [31:0] d;
    do_read(a, tag, d);
    check(tag, {32'd0, d}, {32'd0, exp});
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [31:0] v1, v2;

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0;
    idle(3);
    check("reset_valid", {63'd0, readdatavalid}, 64'd0);
    check("reset_data", {32'd0, readdata}, 64'd0);
    reset = 1'b0;

    rd_chk(4'd0, "id", 32'h0000_0000);
    idle(1);
    check("valid_pulse", {63'd0, readdatavalid}, 64'd0);
    rd_chk(4'd1, "timestamp", 32'd1496327636);
    rd_chk(4'd2, "caps", 32'h0002_0002);
    rd_chk(4'd3, "ctrl_reset", 32'h1);
    rd_chk(4'd5, "shadow_reset", 32'h0);

    do_write(4'd8, 32'hA5A5_A5A5, 4'hF);
    do_write(4'd8, 32'h1234_5678, 4'b0101);
    rd_chk(4'd8, "scratch0_be", 32'hA534_A578);
    do_write(4'd9, 32'hDEAD_BEEF, 4'hF);
    rd_chk(4'd9, "scratch1", 32'hDEAD_BEEF);
    do_write(4'd6, 32'hFFFF_FFFF, 4'hF);
    do_write(4'd15, 32'hFFFF_FFFF, 4'hF);
    rd_chk(4'd6, "unmapped6", 32'h0);
    rd_chk(4'd15, "unmapped15", 32'h0);
    rd_chk(4'd8, "scratch0_kept", 32'hA534_A578);

    // Read and write together: read returns the pre-write value.
    address = 4'd8; writedata = 32'h0BAD_F00D; byteenable = 4'hF;
    read = 1'b1; write = 1'b1;
    @(posedge clock);
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    check("rw_same_cycle", {32'd0, readdata}, {32'd0, 32'hA534_A578});
    rd_chk(4'd8, "rw_after", 32'h0BAD_F00D);

    // Coherent readout across a low-word wrap.
    force dut.uptime_q = 64'h0000_0001_FFFF_FFFF;
    address = 4'd4; read = 1'b1;
    @(posedge clock);
    @(negedge clock);
    release dut.uptime_q;
    read = 1'b0;
    check("uplo_forced", {32'd0, readdata}, {32'd0, 32'hFFFF_FFFF});
    idle(2);
    rd_chk(4'd5, "uphi_coherent", 32'h1);
    do_read(4'd4, "uplo_after", v1);
    rd_chk(4'd5, "uphi_wrapped", 32'h2);

    do_write(4'd3, 32'h0, 4'hF);
    do_read(4'd4, "freeze_a", v1);
    idle(100);
    do_read(4'd4, "freeze_b", v2);
    check("frozen", {32'd0, v2}, {32'd0, v1});
    rd_chk(4'd3, "ctrl_off", 32'h0);

    do_write(4'd3, 32'h3, 4'hF);
    rd_chk(4'd4, "clr_zero", 32'h0);
    rd_chk(4'd4, "clr_inc", 32'h1);
    rd_chk(4'd3, "ctrl_clr_reads0", 32'h1);

    idle(4);
    do_write(4'd3, 32'h2, 4'hF);
    rd_chk(4'd4, "clr_stop_a", 32'h0);
    idle(5);
    rd_chk(4'd4, "clr_stop_b", 32'h0);

    do_write(4'd3, 32'h1, 4'hF);
    address = 4'd4; read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("stream_valid%0d", i), {63'd0, readdatavalid}, 64'd1);
      check($sformatf("stream_val%0d", i), {32'd0, readdata}, 64'(i));
    end
    read = 1'b0;
    idle(1);
    check("stream_end", {63'd0, readdatavalid}, 64'd0);

    do_write(4'd3, 32'h0, 4'hF);
    address = 4'd8; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
    read = 1'b1; write = 1'b1; reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("reset_cycle_valid", {63'd0, readdatavalid}, 64'd0);
    reset = 1'b0; read = 1'b0; write = 1'b0;
    rd_chk(4'd4, "post_reset_cnt0", 32'h0);
    rd_chk(4'd8, "post_reset_scratch", 32'h0);
    rd_chk(4'd3, "post_reset_ctrl", 32'h1);
    rd_chk(4'd4, "post_reset_cnt3", 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
